// File: rtl/alarm_pkg.sv
// rtl/alarm_pkg.sv - shared types and constants for the alarm compare controller
package alarm_pkg;

    typedef enum logic {
        SC_IDLE,
        SC_RUN
    } scan_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_RING,
        R_SNOOZE
    } ring_state_t;

    localparam int SNOOZE_S_DEF = 300;
    localparam int RING_S_DEF   = 60;

    function automatic int ch_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/alarm_ch_bank.sv
// rtl/alarm_ch_bank.sv - alarm time/arm register file with one write port and one read port
module alarm_ch_bank #(
    parameter int NUM_CH = 4,
    parameter int TIME_W = 17,
    parameter int CH_W   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [TIME_W-1:0] wr_time,
    input  logic              wr_arm,
    input  logic [CH_W-1:0]   rd_idx,
    output logic [TIME_W-1:0] rd_time,
    output logic              rd_arm
);

    logic [TIME_W-1:0] tm_q  [NUM_CH];
    logic              arm_q [NUM_CH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                tm_q[i]  <= '0;
                arm_q[i] <= 1'b0;
            end
        end else if (wr_en && (int'(wr_ch) < NUM_CH)) begin
            tm_q[wr_ch]  <= wr_time;
            arm_q[wr_ch] <= wr_arm;
        end
    end

    // Read from the registered copy so a same-cycle write is not seen yet.
    assign rd_time = tm_q[rd_idx];
    assign rd_arm  = arm_q[rd_idx];

endmodule

// File: rtl/alarm_compare_ctrl.sv
// rtl/alarm_compare_ctrl.sv - multi-channel alarm scanner with ring/snooze/timeout state machine
module alarm_compare_ctrl
    import alarm_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int TIME_W   = 17,
    parameter int SNOOZE_S = SNOOZE_S_DEF,
    parameter int RING_S   = RING_S_DEF,
    localparam int CH_W    = ch_w(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tick_1hz,
    input  logic [TIME_W-1:0] now_sec,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [TIME_W-1:0] wr_time,
    input  logic              wr_arm,
    input  logic              ack,
    input  logic              snooze,
    output logic              alarm,
    output logic [CH_W-1:0]   alarm_ch,
    output logic              snoozing,
    output logic [NUM_CH-1:0] pending,
    output logic              scan_busy,
    output logic              missed,
    output logic              overrun
);

    localparam int SNZ_W = (SNOOZE_S < 1) ? 1 : $clog2(SNOOZE_S + 1);
    localparam int RNG_W = (RING_S < 1) ? 1 : $clog2(RING_S + 1);

    scan_state_t       sc_q, sc_d;
    logic [CH_W-1:0]   idx_q, idx_d;
    logic [TIME_W-1:0] now_q, now_d;
    logic              overrun_q, overrun_d;

    ring_state_t       rs_q, rs_d;
    logic [CH_W-1:0]   ach_q, ach_d;
    logic [RNG_W-1:0]  ring_cnt_q, ring_cnt_d;
    logic [SNZ_W-1:0]  snz_cnt_q, snz_cnt_d;
    logic              missed_q, missed_d;
    logic [NUM_CH-1:0] pending_q, pending_d;

    logic [TIME_W-1:0] rd_time;
    logic              rd_arm;
    logic              hit;
    logic              cancel;
    logic [CH_W-1:0]   low_idx;
    logic [NUM_CH-1:0] set_mask, clr_mask;

    alarm_ch_bank #(
        .NUM_CH (NUM_CH),
        .TIME_W (TIME_W),
        .CH_W   (CH_W)
    ) u_bank (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_ch   (wr_ch),
        .wr_time (wr_time),
        .wr_arm  (wr_arm),
        .rd_idx  (idx_q),
        .rd_time (rd_time),
        .rd_arm  (rd_arm)
    );

    always_comb begin
        sc_d      = sc_q;
        idx_d     = idx_q;
        now_d     = now_q;
        overrun_d = overrun_q;
        case (sc_q)
            SC_IDLE: begin
                if (tick_1hz) begin
                    now_d = now_sec;
                    idx_d = '0;
                    sc_d  = SC_RUN;
                end
            end
            SC_RUN: begin
                if (tick_1hz) begin
                    overrun_d = 1'b1;
                end
                if (idx_q == CH_W'(NUM_CH - 1)) begin
                    sc_d = SC_IDLE;
                end else begin
                    idx_d = idx_q + CH_W'(1);
                end
            end
            default: sc_d = SC_IDLE;
        endcase
    end

    assign hit    = (sc_q == SC_RUN) && rd_arm && (rd_time == now_q);
    assign cancel = wr_en && !wr_arm && (wr_ch == ach_q) && (rs_q != R_IDLE);

    always_comb begin
        low_idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                low_idx = CH_W'(i);
            end
        end
    end

    always_comb begin
        rs_d       = rs_q;
        ach_d      = ach_q;
        ring_cnt_d = ring_cnt_q;
        snz_cnt_d  = snz_cnt_q;
        missed_d   = 1'b0;
        set_mask   = '0;
        clr_mask   = '0;
        if (hit) begin
            set_mask[idx_q] = 1'b1;
        end
        if (cancel) begin
            clr_mask[wr_ch] = 1'b1;
        end
        case (rs_q)
            R_IDLE: begin
                if (|pending_q) begin
                    rs_d              = R_RING;
                    ach_d             = low_idx;
                    clr_mask[low_idx] = 1'b1;
                    ring_cnt_d        = '0;
                end
            end
            R_RING: begin
                if (cancel || ack) begin
                    rs_d = R_IDLE;
                end else if (snooze) begin
                    rs_d      = R_SNOOZE;
                    snz_cnt_d = SNZ_W'(SNOOZE_S);
                end else if (tick_1hz) begin
                    if (ring_cnt_q >= RNG_W'(RING_S - 1)) begin
                        missed_d   = 1'b1;
                        rs_d       = R_IDLE;
                        ring_cnt_d = RNG_W'(RING_S);
                    end else begin
                        ring_cnt_d = ring_cnt_q + RNG_W'(1);
                    end
                end
            end
            R_SNOOZE: begin
                if (cancel) begin
                    rs_d = R_IDLE;
                end else if (tick_1hz) begin
                    if (snz_cnt_q <= SNZ_W'(1)) begin
                        rs_d       = R_RING;
                        snz_cnt_d  = '0;
                        ring_cnt_d = '0;
                    end else begin
                        snz_cnt_d = snz_cnt_q - SNZ_W'(1);
                    end
                end
            end
            default: rs_d = R_IDLE;
        endcase
        // A fresh match wins over a same-cycle clear so it is never lost.
        pending_d = (pending_q & ~clr_mask) | set_mask;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sc_q       <= SC_IDLE;
            idx_q      <= '0;
            now_q      <= '0;
            overrun_q  <= 1'b0;
            rs_q       <= R_IDLE;
            ach_q      <= '0;
            ring_cnt_q <= '0;
            snz_cnt_q  <= '0;
            missed_q   <= 1'b0;
            pending_q  <= '0;
        end else begin
            sc_q       <= sc_d;
            idx_q      <= idx_d;
            now_q      <= now_d;
            overrun_q  <= overrun_d;
            rs_q       <= rs_d;
            ach_q      <= ach_d;
            ring_cnt_q <= ring_cnt_d;
            snz_cnt_q  <= snz_cnt_d;
            missed_q   <= missed_d;
            pending_q  <= pending_d;
        end
    end

    assign alarm     = (rs_q == R_RING);
    assign snoozing  = (rs_q == R_SNOOZE);
    assign alarm_ch  = ach_q;
    assign pending   = pending_q;
    assign scan_busy = (sc_q == SC_RUN);
    assign missed    = missed_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_alarm_compare_ctrl.sv
// tb/tb_alarm_compare_ctrl.sv - directed and randomized self-checking bench for alarm_compare_ctrl
module tb_alarm_compare_ctrl;

    localparam int NUM_CH   = 4;
    localparam int TIME_W   = 17;
    localparam int SNOOZE_S = 3;
    localparam int RING_S   = 2;
    localparam int CH_W     = 2;

    logic              clk      = 1'b0;
    logic              rst_n    = 1'b0;
    logic              tick_1hz = 1'b0;
    logic [TIME_W-1:0] now_sec  = '0;
    logic              wr_en    = 1'b0;
    logic [CH_W-1:0]   wr_ch    = '0;
    logic [TIME_W-1:0] wr_time  = '0;
    logic              wr_arm   = 1'b0;
    logic              ack      = 1'b0;
    logic              snooze   = 1'b0;
    logic              alarm;
    logic [CH_W-1:0]   alarm_ch;
    logic              snoozing;
    logic [NUM_CH-1:0] pending;
    logic              scan_busy;
    logic              missed;
    logic              overrun;

    int n_asserts = 0;
    int n_fail    = 0;

    int m_time [NUM_CH];
    bit m_arm  [NUM_CH];

    alarm_compare_ctrl #(
        .NUM_CH   (NUM_CH),
        .TIME_W   (TIME_W),
        .SNOOZE_S (SNOOZE_S),
        .RING_S   (RING_S)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick_1hz  (tick_1hz),
        .now_sec   (now_sec),
        .wr_en     (wr_en),
        .wr_ch     (wr_ch),
        .wr_time   (wr_time),
        .wr_arm    (wr_arm),
        .ack       (ack),
        .snooze    (snooze),
        .alarm     (alarm),
        .alarm_ch  (alarm_ch),
        .snoozing  (snoozing),
        .pending   (pending),
        .scan_busy (scan_busy),
        .missed    (missed),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wr(input int ch, input int t, input bit arm);
        wr_en   = 1'b1;
        wr_ch   = CH_W'(ch);
        wr_time = TIME_W'(t);
        wr_arm  = arm;
        m_time[ch] = t;
        m_arm[ch]  = arm;
        step(1);
        wr_en  = 1'b0;
        wr_arm = 1'b0;
    endtask

    task automatic tick(input int now);
        now_sec  = TIME_W'(now);
        tick_1hz = 1'b1;
        step(1);
        tick_1hz = 1'b0;
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        step(1);
        ack = 1'b0;
    endtask

    function automatic int match_mask(input int now);
        int m = 0;
        for (int c = 0; c < NUM_CH; c++)
            if (m_arm[c] && m_time[c] == now) m |= (1 << c);
        return m;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_alarm"}, alarm, 0);
        check({tag, "_alarm_ch"}, alarm_ch, 0);
        check({tag, "_snoozing"}, snoozing, 0);
        check({tag, "_pending"}, pending, 0);
        check({tag, "_scan_busy"}, scan_busy, 0);
        check({tag, "_missed"}, missed, 0);
        check({tag, "_overrun"}, overrun, 0);
    endtask

    initial begin
        int q[$];
        int m, now;

        for (int c = 0; c < NUM_CH; c++) begin
            m_time[c] = 0;
            m_arm[c]  = 1'b0;
        end

        step(2);
        check_all_zero("reset");
        rst_n = 1'b1;
        step(1);

        // Single match on ch2 with exact latency
        wr(2, 3600, 1'b1);
        tick(3600);
        check("t1_busy", scan_busy, 1);
        step(3);
        check("t1_pend_t4", pending, 4'b0100);
        check("t1_alarm_t4", alarm, 0);
        step(1);
        check("t1_alarm_t5", alarm, 1);
        check("t1_ch_t5", alarm_ch, 2);
        check("t1_pend_t5", pending, 0);
        pulse_ack();
        check("t1_ack", alarm, 0);

        // Two matches ring lowest first
        wr(1, 100, 1'b1);
        wr(3, 100, 1'b1);
        tick(100);
        step(3);
        check("t2_alarm", alarm, 1);
        check("t2_ch1", alarm_ch, 1);
        step(1);
        check("t2_pend3", pending, 4'b1000);
        pulse_ack();
        check("t2_ack1", alarm, 0);
        step(1);
        check("t2_alarm3", alarm, 1);
        check("t2_ch3", alarm_ch, 3);
        check("t2_pend0", pending, 0);
        pulse_ack();
        check("t2_ack3", alarm, 0);

        // Snooze for SNOOZE_S ticks then ring again
        wr(3, 100, 1'b0);
        step(5);
        tick(100);
        step(3);
        check("t3_ring", alarm, 1);
        snooze = 1'b1;
        step(1);
        snooze = 1'b0;
        check("t3_alarm_off", alarm, 0);
        check("t3_snoozing", snoozing, 1);
        check("t3_ch", alarm_ch, 1);
        for (int i = 0; i < SNOOZE_S; i++) begin
            step(5);
            tick(5);
            if (i < SNOOZE_S - 1) begin
                check("t3_still_snz", snoozing, 1);
                check("t3_still_off", alarm, 0);
            end else begin
                check("t3_rering", alarm, 1);
                check("t3_rering_ch", alarm_ch, 1);
                check("t3_snz_off", snoozing, 0);
            end
        end

        // Ring timeout after RING_S ticks
        step(5);
        tick(5);
        check("t4_alarm_1st", alarm, 1);
        check("t4_missed_1st", missed, 0);
        step(5);
        tick(5);
        check("t4_missed", missed, 1);
        check("t4_alarm_off", alarm, 0);
        step(1);
        check("t4_missed_pulse", missed, 0);

        // Ack and snooze together: ack wins
        step(5);
        tick(100);
        step(3);
        check("t5_ring", alarm, 1);
        ack    = 1'b1;
        snooze = 1'b1;
        step(1);
        ack    = 1'b0;
        snooze = 1'b0;
        check("t5_alarm", alarm, 0);
        check("t5_snoozing", snoozing, 0);
        step(1);
        check("t5_snoozing2", snoozing, 0);

        // Disarm while ringing cancels and stays disarmed
        step(5);
        tick(100);
        step(3);
        check("t5c_ring", alarm, 1);
        wr(1, 100, 1'b0);
        check("t5c_cancel", alarm, 0);
        check("t5c_pend", pending, 0);
        step(5);
        tick(100);
        step(5);
        check("t5c_noring", alarm, 0);
        check("t5c_nopend", pending, 0);

        // Overrun: second tick two cycles after the first is dropped
        check("t6_ovr0", overrun, 0);
        wr(2, 50, 1'b1);
        step(5);
        tick(50);
        step(1);
        tick(50);
        check("t6_overrun", overrun, 1);
        check("t6_busy_t3", scan_busy, 1);
        step(1);
        check("t6_busy_t4", scan_busy, 1);
        check("t6_pend_t4", pending, 4'b0100);
        step(1);
        check("t6_busy_t5", scan_busy, 0);
        check("t6_alarm_t5", alarm, 1);
        check("t6_ch_t5", alarm_ch, 2);
        step(1);
        check("t6_busy_t6", scan_busy, 0);
        check("t6_pend_t6", pending, 0);

        // Asynchronous reset mid-ring
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_mid");
        rst_n = 1'b1;
        for (int c = 0; c < NUM_CH; c++) begin
            m_time[c] = 0;
            m_arm[c]  = 1'b0;
        end
        step(1);
        tick(0);
        step(5);
        check("rst_bank_alarm", alarm, 0);
        check("rst_bank_pend", pending, 0);

        // Randomized programming against the queue model
        for (int it = 0; it < 24; it++) begin
            for (int c = 0; c < NUM_CH; c++)
                wr(c, 10 * (1 + int'($urandom_range(0, 2))), 1'($urandom_range(0, 1)));
            step(5);
            now = 10 * (1 + int'($urandom_range(0, 2)));
            m = match_mask(now);
            q.delete();
            for (int c = 0; c < NUM_CH; c++)
                if (m[c]) q.push_back(c);
            tick(now);
            step(5);
            if (q.size() == 0) begin
                check("rnd_noalarm", alarm, 0);
                check("rnd_nopend", pending, 0);
            end else begin
                check("rnd_alarm", alarm, 1);
                check("rnd_first_ch", alarm_ch, q[0]);
                check("rnd_pend", pending, m & ~(1 << q[0]));
                for (int j = 1; j < q.size(); j++) begin
                    pulse_ack();
                    check("rnd_ack_off", alarm, 0);
                    step(1);
                    check("rnd_next_alarm", alarm, 1);
                    check("rnd_next_ch", alarm_ch, q[j]);
                end
                pulse_ack();
                check("rnd_done_alarm", alarm, 0);
                check("rnd_done_pend", pending, 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
